// File: rtl/id_stage_param.sv
// Parametrised ID stage: register file with write-through bypass, main decoder,
// branch resolution with MEM forwarding, hazard detection, ID/EX register and perf counters.
module id_stage_param #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int IMM_W    = 16,
  parameter  int BR_SHIFT = 2,
  parameter  int CNT_W    = 16,
  localparam int RAW      = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  next_addr,
  input  logic             wb_we,
  input  logic [RAW-1:0]   wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [RAW-1:0]   mem_rd,
  input  logic [XLEN-1:0]  mem_alu,
  output logic [XLEN-1:0]  branch_addr,
  output logic             pc_src,
  output logic             flush,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [3:0]       ex_ctrl,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       wb_ctrl,
  output logic [RAW-1:0]   rs_o,
  output logic [RAW-1:0]   rt_o,
  output logic [RAW-1:0]   rd_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [XLEN-1:0]  data1,
  output logic [XLEN-1:0]  data2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  function automatic logic [RAW-1:0] fld(input logic [4:0] f);
    logic [RAW+4:0] w;
    w = {{RAW{1'b0}}, f};
    return w[RAW-1:0];
  endfunction

  logic [XLEN-1:0] rf_reg [NREG];

  logic [3:0]       ex_ctrl_reg;
  logic             mem_read_reg, mem_write_reg;
  logic [1:0]       wb_ctrl_reg;
  logic [RAW-1:0]   rs_reg, rt_reg, rd_reg;
  logic [XLEN-1:0]  imm_reg, data1_reg, data2_reg;
  logic [CNT_W-1:0] stall_cnt_reg, taken_cnt_reg;

  // Decoder
  logic [5:0] op;
  logic       regdst, alusrc, memread, memwrite, regwrite, memtoreg;
  logic [1:0] aluop;
  logic       is_beq, is_bne, is_branch, use_rs, use_rt;

  assign op = instr[31:26];

  always_comb begin
    regdst   = 1'b0;
    aluop    = 2'b00;
    alusrc   = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    use_rs   = 1'b1;
    use_rt   = 1'b0;
    case (op)
      6'h00: begin regdst = 1'b1; aluop = 2'b10; regwrite = 1'b1; use_rt = 1'b1; end
      6'h23: begin alusrc = 1'b1; memread = 1'b1; regwrite = 1'b1; memtoreg = 1'b1; end
      6'h2B: begin alusrc = 1'b1; memwrite = 1'b1; use_rt = 1'b1; end
      6'h08: begin alusrc = 1'b1; regwrite = 1'b1; end
      6'h04: begin aluop = 2'b01; is_beq = 1'b1; use_rt = 1'b1; end
      6'h05: begin aluop = 2'b01; is_bne = 1'b1; use_rt = 1'b1; end
      default: use_rs = 1'b0;
    endcase
  end

  assign is_branch = is_beq | is_bne;

  logic [XLEN-1:0] imm_sext;
  assign imm_sext    = XLEN'($signed(instr[IMM_W-1:0]));
  assign branch_addr = next_addr + (imm_sext << BR_SHIFT);

  // Per-source-port read, forwarding and hazard matching (port 0 = rs, port 1 = rt)
  logic [1:0][RAW-1:0]  src_idx;
  logic [1:0][XLEN-1:0] src_rf, src_cmp;
  logic [1:0]           src_used, lu_hit, ex_hit, mem_hit;
  logic                 idex_regwrite;
  logic [RAW-1:0]       idex_dest;

  assign src_idx[0]    = fld(instr[25:21]);
  assign src_idx[1]    = fld(instr[20:16]);
  assign src_used      = {use_rt, use_rs};
  assign idex_regwrite = wb_ctrl_reg[1];
  assign idex_dest     = ex_ctrl_reg[3] ? rd_reg : rt_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic nz;
      assign nz           = src_used[gi] && (src_idx[gi] != '0);
      assign src_rf[gi]   = (src_idx[gi] == '0) ? '0 :
                            (wb_we && wb_addr == src_idx[gi]) ? wb_data : rf_reg[src_idx[gi]];
      assign src_cmp[gi]  = (mem_regwrite && !mem_memread && mem_rd == src_idx[gi] &&
                             src_idx[gi] != '0) ? mem_alu : src_rf[gi];
      assign lu_hit[gi]   = nz && mem_read_reg && (rt_reg == src_idx[gi]);
      assign ex_hit[gi]   = nz && idex_regwrite && (idex_dest == src_idx[gi]);
      assign mem_hit[gi]  = nz && mem_regwrite && mem_memread && (mem_rd == src_idx[gi]);
    end
  endgenerate

  logic stall, taken, src_eq;
  assign src_eq = (src_cmp[0] == src_cmp[1]);
  // Reset forces the stage to look idle: no stall and no redirect while rst is low.
  assign stall  = rst && ((|lu_hit) || (is_branch && ((|ex_hit) || (|mem_hit))));
  assign taken  = rst && !stall && ((is_beq && src_eq) || (is_bne && !src_eq));

  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign pc_src     = taken;
  assign flush      = taken;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      rf_reg[wb_addr] <= wb_data;
    end
  end

  // ID/EX register; a stall inserts an all-zero bubble
  always_ff @(posedge clk) begin
    if (!rst || stall) begin
      ex_ctrl_reg   <= '0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      wb_ctrl_reg   <= '0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      rd_reg        <= '0;
      imm_reg       <= '0;
      data1_reg     <= '0;
      data2_reg     <= '0;
    end else begin
      ex_ctrl_reg   <= {regdst, aluop, alusrc};
      mem_read_reg  <= memread;
      mem_write_reg <= memwrite;
      wb_ctrl_reg   <= {regwrite, memtoreg};
      rs_reg        <= src_idx[0];
      rt_reg        <= src_idx[1];
      rd_reg        <= fld(instr[15:11]);
      imm_reg       <= imm_sext;
      data1_reg     <= src_rf[0];
      data2_reg     <= src_rf[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      taken_cnt_reg <= '0;
    end else begin
      if (stall && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (taken && taken_cnt_reg != '1) taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
    end
  end

  assign ex_ctrl   = ex_ctrl_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign wb_ctrl   = wb_ctrl_reg;
  assign rs_o      = rs_reg;
  assign rt_o      = rt_reg;
  assign rd_o      = rd_reg;
  assign imm_o     = imm_reg;
  assign data1     = data1_reg;
  assign data2     = data2_reg;
  assign stall_cnt = stall_cnt_reg;
  assign taken_cnt = taken_cnt_reg;

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
Parametrised instruction-decode stage: successor to the fixed 32-bit ID stage.
- Contains the register file (with write-through bypass), the main decoder and sign extension.
- Resolves beq/bne in ID, forwarding the MEM-stage ALU result into the comparator.
- Detects load-use and branch-operand hazards, and owns the ID/EX pipeline register.
- Adds saturating stall and taken-branch performance counters.
- Sits between IF/ID and EX.

Parameters:
XLEN, 32, datapath/register width (>=16)
NREG, 32, number of architectural registers (power of two, >=8); RAW = log2(NREG)
IMM_W, 16, immediate field width in instr[IMM_W-1:0]
BR_SHIFT, 2, left shift applied to the sign-extended immediate for branch offset
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets at the edge)
instr  in  32  IF/ID instruction; op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], fields truncated/zero-padded to RAW
next_addr  in  XLEN  PC+4 of the instruction in ID
wb_we  in  1  write-back enable
wb_addr  in  RAW  write-back register
wb_data  in  XLEN  write-back data
mem_regwrite  in  1  MEM-stage RegWrite
mem_memread  in  1  MEM-stage MemRead
mem_rd  in  RAW  MEM-stage destination register
mem_alu  in  XLEN  MEM-stage ALU result
branch_addr  out  XLEN  next_addr + (sext(imm) << BR_SHIFT), combinational
pc_src  out  1  taken branch, select branch_addr
flush  out  1  flush IF/ID (equals pc_src)
pc_write  out  1  PC enable (0 on stall)
ifid_write  out  1  IF/ID enable (0 on stall)
ex_ctrl  out  4  registered {RegDst, ALUOp[1:0], ALUSrc}
mem_read, mem_write  out  1 each  registered M controls
wb_ctrl  out  2  registered {RegWrite, MemtoReg}
rs_o, rt_o, rd_o  out  RAW  registered register indices
imm_o, data1, data2  out  XLEN  registered sign-extended immediate and operands
stall_cnt, taken_cnt  out  CNT_W  saturating counters

Behaviour:
Decode (opcode -> {RegDst, ALUOp, ALUSrc | MemRead, MemWrite | RegWrite, MemtoReg}):
- R 0x00 -> 1,10,0 | 0,0 | 1,0
- lw 0x23 -> 0,00,1 | 1,0 | 1,1
- sw 0x2B -> 0,00,1 | 0,1 | 0,0
- addi 0x08 -> 0,00,1 | 0,0 | 1,0
- beq 0x04 and bne 0x05 -> ALUOp 01, all other controls 0
- any other opcode -> all controls 0 (NOP)

Register file:
- NREG x XLEN; register 0 reads 0 and ignores writes.
- Write at the edge when wb_we=1.
- Same-cycle read of wb_addr (non-zero) returns wb_data (bypass).

Operand use:
- rs is used by every decoded opcode except NOP.
- rt is used by R-type, sw, beq and bne only.
- Index 0 never causes a hazard.

Hazards (combinational, evaluated in ID):
- Load-use: ID/EX mem_read=1 and ID/EX rt_o equals a used source -> stall.
- Branch in ID:
  - Stall if the ID/EX entry has RegWrite=1 and its destination (rd_o if RegDst=1, else rt_o) equals a source.
  - Stall if mem_regwrite and mem_memread are both 1 and mem_rd equals a source.
  - A load feeding a branch therefore stalls exactly 2 cycles; an ALU producer in EX stalls 1 cycle.
- During a stall:
  - pc_write=0, ifid_write=0, pc_src=0, flush=0.
  - ID/EX captures a bubble: all control bits 0; indices and data are don't-care but driven 0.

Comparator:
- Each source value is mem_alu if mem_regwrite=1, mem_memread=0, mem_rd==src and src!=0; otherwise the register-file or bypass value.
- Taken when beq and equal, or bne and not equal, with no stall active.
- pc_src=flush=1 in that same cycle.

ID/EX register:
- Updates every cycle (never held).
- Captures decoded controls, rs, rt, rd, the sign-extended imm (IMM_W to XLEN) and the source values.
- The captured source values are register-file/bypass values, not the comparator-forwarded values.

Counters:
- stall_cnt increments each stall cycle; taken_cnt increments each taken branch.
- Both saturate at all-ones.

Reset (rst=0 at an edge):
- All ID/EX outputs, register-file contents and counters become 0.
- pc_write and ifid_write are forced to 1, pc_src and flush to 0, while rst=0.
- Reset overrides a stall or branch in the same cycle.

Test Plan:
- Reset, then read r5 -> data1=0, all controls 0, counters 0; write r5=0x1234 via wb and read r5 in the same cycle -> bypass gives 0x1234.
- lw r2 in EX, then add r3,r2,r4 in ID -> one cycle with pc_write=0, a bubble into ID/EX and stall_cnt=1; add issues on the next cycle.
- addi r7 in EX, then beq r7,r0 in ID -> 1 stall; on the next cycle mem_alu=0 is forwarded, pc_src=flush=1, branch_addr=next_addr+(imm<<2), taken_cnt=1.
- lw r8 in EX, then bne r8,r9 in ID -> exactly 2 stall cycles, then resolution from the register file with wb bypass.
- Negative immediate 0xFFFC with next_addr=0x100 -> branch_addr=0x0F0; opcode 0x3F -> all controls 0, no stall.
- Assert rst=0 mid-stall -> next edge clears ID/EX and counters; pc_write=1 while held.
